instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid_i  in  1  request valid.
REQ-004 SHALL have ports: in_ready_o  out  1  request accepted when in_valid_i and in_ready_o are both high at a clk edge.
REQ-005 SHALL have ports: opcode_i  in  7, rd_i  in  5, rs1_i  in  5, rs2_i  in  5, funct3_i  in  3, funct7_i  in  7, all instruction fields.
REQ-006 SHALL have ports: imm_i  in  32  signed byte-offset or immediate value.
REQ-007 SHALL have ports: out_valid_o  out  1, out_ready_i  in  1, output handshake.
REQ-008 SHALL have ports: instr_o  out  32  encoded RV32I word.
REQ-009 SHALL have ports: err_o  out  1  entry was unencodable.
REQ-010 SHALL have ports: err_cnt_o  out  8  saturating error count.

Function
REQ-011 SHALL select the format from opcode_i: 0000011/1100111/0010011 -> I; 0100011 -> S; 1100011 -> B; 1101111 -> J; 0110011 -> R; any other opcode -> unsupported.
REQ-012 SHALL encode I as imm[11:0],rs1,funct3,rd,opcode.
REQ-013 SHALL encode S as imm[11:5],rs2,rs1,funct3,imm[4:0],opcode.
REQ-014 SHALL encode B as imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode.
REQ-015 SHALL encode J as imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode.
REQ-016 SHALL encode R as funct7,rs2,rs1,funct3,rd,opcode and ignore imm_i.
REQ-017 SHALL flag an error when the immediate is out of range: I/S outside [-2048,2047]; B outside [-4096,4094] or imm_i[0]=1; J outside [-1048576,1048574] or imm_i[0]=1; also flag an error for an unsupported opcode.
REQ-018 SHALL store instr_o=32'h00000013 (NOP) with err_o=1 for any flagged entry.
REQ-019 SHALL buffer results in a 2-entry FIFO; in_ready_o=1 iff occupancy<2.
REQ-020 SHALL have latency 1: an entry accepted at edge N appears on out_valid_o/instr_o/err_o after edge N, when the FIFO is otherwise empty.
REQ-021 SHALL present entries in acceptance order; instr_o/err_o SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-022 SHALL pop on out_valid_o&out_ready_i; simultaneous push and pop at occupancy 1 SHALL leave occupancy 1.
REQ-023 SHALL ignore out_ready_i when empty and in_valid_i when full.
REQ-024 SHALL increment err_cnt_o by 1 on each accepted erroneous request and saturate at 255.

Reset
REQ-025 SHALL, while rst_n=0 (including mid-transfer), clear the FIFO and drive in_ready_o=1, out_valid_o=0, instr_o=0, err_o=0, err_cnt_o=0; in-flight entries SHALL be discarded.
REQ-026 SHALL accept the first request at the first rising clk edge after rst_n deasserts.

Structure
REQ-027 SHALL take opcode constants, the format enumeration (I,S,B,J,R,UNSUP) and the NOP constant from a shared package, rv32_pkg.
REQ-028 SHALL implement the storage as a sub-module, enc_fifo2 (2 entries, 33-bit data), with the encoder itself purely combinational in front of it.

Verification
REQ-029 SHALL cover: lw with rd=1, rs1=2, f3=010, imm=4 -> instr_o=0x00412083, err_o=0, one cycle later.
REQ-030 SHALL cover: sw with rs2=5, rs1=2, f3=010, imm=8 -> 0x00512423; beq with rs1=1, rs2=2, f3=000, imm=-4 -> 0xFE208EE3.
REQ-031 SHALL cover: jal with rd=0, imm=2048 -> 0x0010006F; addi imm=2048 -> 0x00000013, err_o=1, err_cnt_o=1; beq imm=3 -> err_o=1.
REQ-032 SHALL cover: out_ready_i=0 with 3 back-to-back requests -> in_ready_o=0 after 2 accepts; releasing out_ready_i -> all 3 emerge in order, each stable while stalled.
REQ-033 SHALL cover: 300 erroneous requests -> err_cnt_o=255 held; rst_n pulsed low with 2 entries queued -> out_valid_o=0, err_cnt_o=0 immediately.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants, instruction format enumeration and opcode decode.
package rv32_pkg;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [2:0] {FmtI, FmtS, FmtB, FmtJ, FmtR, FmtUnsup} fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] opcode);
    fmt_e fmt;
    case (opcode)
      OpcLoad, OpcJalr, OpcOpImm: fmt = FmtI;
      OpcStore:                   fmt = FmtS;
      OpcBranch:                  fmt = FmtB;
      OpcJal:                     fmt = FmtJ;
      OpcOp:                      fmt = FmtR;
      default:                    fmt = FmtUnsup;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder; slave is the encoder side.
interface instr_encoder_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [6:0]  opcode_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] imm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] instr_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  modport slave (
    input  in_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, instr_o, err_o, err_cnt_o
  );

  modport master (
    output in_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, instr_o, err_o, err_cnt_o
  );
endinterface

// File: rtl/enc_fifo2.sv
// Two-entry FIFO holding {err, instr}; push ignored when full, pop ignored when empty.
module enc_fifo2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [32:0] wdata,
  output logic        ready,
  input  logic        pop,
  output logic        valid,
  output logic [32:0] rdata
);

  logic [32:0] mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  cnt_q;
  logic        do_push, do_pop;

  assign ready   = (cnt_q != 2'd2);
  assign valid   = (cnt_q != 2'd0);
  assign do_push = push & ready;
  assign do_pop  = pop & valid;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage is cleared too, so the output word reads zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Combinational RV32I field encoder with range checking, buffered by a 2-entry FIFO.
module instr_encoder
  import rv32_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  instr_encoder_if.slave   bus
);

  fmt_e               fmt;
  logic signed [31:0] imm_s;
  logic [31:0]        imm;
  logic [31:0]        enc;
  logic               bad;
  logic [32:0]        entry;
  logic               accept;
  logic [7:0]         err_cnt_q;

  assign imm   = bus.imm_i;
  assign imm_s = $signed(bus.imm_i);
  assign fmt   = fmt_of(bus.opcode_i);

  always_comb begin
    enc = Nop;
    bad = 1'b0;
    unique case (fmt)
      FmtI: begin
        enc = {imm[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
        bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FmtS: begin
        enc = {imm[11:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:0], bus.opcode_i};
        bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FmtB: begin
        enc = {imm[12], imm[10:5], bus.rs2_i, bus.rs1_i, bus.funct3_i, imm[4:1], imm[11],
               bus.opcode_i};
        bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
      end
      FmtJ: begin
        enc = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd_i, bus.opcode_i};
        bad = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
      end
      FmtR: begin
        enc = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, bus.opcode_i};
      end
      default: begin
        bad = 1'b1;
      end
    endcase
    entry = bad ? {1'b1, Nop} : {1'b0, enc};
  end

  logic [32:0] head;

  enc_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid_i),
    .wdata (entry),
    .ready (bus.in_ready_o),
    .pop   (bus.out_ready_i),
    .valid (bus.out_valid_o),
    .rdata (head)
  );

  assign bus.instr_o = head[31:0];
  assign bus.err_o   = head[32];
  assign accept      = bus.in_valid_i & bus.in_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (accept && bad && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard of encoded words checked at every clock.
module tb_instr_encoder;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic [32:0] sb[$];
  logic [7:0]  exp_cnt = 8'd0;
  logic        acc;
  logic        obs_valid, obs_err;
  logic [31:0] obs_instr;
  logic [7:0]  obs_cnt;
  int          n_wait;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
    int          v;
    logic        b;
    logic [31:0] w;
    v = $signed(imm);
    b = 1'b0;
    w = 32'h0;
    if (opc == 7'b0000011 || opc == 7'b1100111 || opc == 7'b0010011) begin
      b = (v < -2048) || (v > 2047);
      w = {imm[11:0], rs1, f3, rd, opc};
    end else if (opc == 7'b0100011) begin
      b = (v < -2048) || (v > 2047);
      w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    end else if (opc == 7'b1100011) begin
      b = (v < -4096) || (v > 4094) || (imm[0] == 1'b1);
      w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
    end else if (opc == 7'b1101111) begin
      b = (v < -1048576) || (v > 1048574) || (imm[0] == 1'b1);
      w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
    end else if (opc == 7'b0110011) begin
      w = {f7, rs2, rs1, f3, rd, opc};
    end else begin
      b = 1'b1;
    end
    return b ? {1'b1, 32'h0000_0013} : {1'b0, w};
  endfunction

  // One clock: check outputs at the falling edge, update the model, return just after rise.
  task automatic cycle();
    logic [32:0] e;
    @(negedge clk);
    check("in_ready", 64'(bus.in_ready_o), 64'(sb.size() < 2));
    check("out_valid", 64'(bus.out_valid_o), 64'(sb.size() != 0));
    check("err_cnt", 64'(bus.err_cnt_o), 64'(exp_cnt));
    if (sb.size() != 0) check("head", 64'({bus.err_o, bus.instr_o}), 64'(sb[0]));
    obs_valid = bus.out_valid_o;
    obs_instr = bus.instr_o;
    obs_err   = bus.err_o;
    obs_cnt   = bus.err_cnt_o;
    acc = bus.in_valid_i && (sb.size() < 2);
    if (bus.out_valid_o && bus.out_ready_i && sb.size() != 0) void'(sb.pop_front());
    if (acc) begin
      e = model(bus.opcode_i, bus.rd_i, bus.rs1_i, bus.rs2_i, bus.funct3_i, bus.funct7_i,
                bus.imm_i);
      sb.push_back(e);
      if (e[32] && exp_cnt != 8'hFF) exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm, output int waited);
    bus.opcode_i = opc; bus.rd_i = rd; bus.rs1_i = rs1; bus.rs2_i = rs2;
    bus.funct3_i = f3; bus.funct7_i = f7; bus.imm_i = imm;
    bus.in_valid_i = 1'b1;
    waited = 0;
    acc = 1'b0;
    while (!acc && waited < 20) begin
      cycle();
      if (!acc) waited++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $error("FAIL accept_timeout: observed no accept expected accept");
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    bus.opcode_i = '0; bus.rd_i = '0; bus.rs1_i = '0; bus.rs2_i = '0;
    bus.funct3_i = '0; bus.funct7_i = '0; bus.imm_i = '0;
    #12;
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_instr", 64'(bus.instr_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    check("rst_cnt", 64'(bus.err_cnt_o), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    req(OpcLoad, 5'd1, 5'd2, 5'd0, 3'b010, 7'd0, 32'd4, n_wait);
    check("first_accept_wait", 64'(n_wait), 64'd0);
    cycle();
    check("lw_latency_valid", 64'(obs_valid), 64'd1);
    check("lw_instr", 64'(obs_instr), 64'h0041_2083);
    check("lw_err", 64'(obs_err), 64'd0);

    req(OpcStore, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8, n_wait);
    cycle();
    check("sw_instr", 64'(obs_instr), 64'h0051_2423);
    req(OpcBranch, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4, n_wait);
    cycle();
    check("beq_instr", 64'(obs_instr), 64'hFE20_8EE3);
    req(OpcJal, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, n_wait);
    cycle();
    check("jal_instr", 64'(obs_instr), 64'h0010_006F);
    req(OpcOpImm, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, n_wait);
    cycle();
    check("addi_oor_instr", 64'(obs_instr), 64'h0000_0013);
    check("addi_oor_err", 64'(obs_err), 64'd1);
    check("addi_oor_cnt", 64'(obs_cnt), 64'd1);
    req(OpcBranch, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, n_wait);
    cycle();
    check("beq_odd_err", 64'(obs_err), 64'd1);

    // Range boundaries and R-type, back to back; the scoreboard model checks each word.
    req(OpcOpImm, 5'd3, 5'd4, 5'd0, 3'b000, 7'd0, -32'sd2048, n_wait);
    req(OpcStore, 5'd0, 5'd4, 5'd6, 3'b010, 7'd0, 32'd2047, n_wait);
    req(OpcStore, 5'd0, 5'd4, 5'd6, 3'b010, 7'd0, -32'sd2049, n_wait);
    req(OpcBranch, 5'd0, 5'd7, 5'd8, 3'b001, 7'd0, 32'd4094, n_wait);
    req(OpcBranch, 5'd0, 5'd7, 5'd8, 3'b001, 7'd0, -32'sd4096, n_wait);
    req(OpcBranch, 5'd0, 5'd7, 5'd8, 3'b001, 7'd0, 32'd4096, n_wait);
    req(OpcJal, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd1048576, n_wait);
    req(OpcJal, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1048574, n_wait);
    req(OpcJal, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1048576, n_wait);
    req(OpcOp, 5'd3, 5'd4, 5'd5, 3'b000, 7'b0100000, 32'hDEAD_BEEF, n_wait);
    req(OpcJalr, 5'd1, 5'd9, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFF0, n_wait);
    req(7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, n_wait);
    drain(3);

    // Stall: two accepts fill the FIFO, the third waits until the sink drains.
    bus.out_ready_i = 1'b0;
    req(OpcOpImm, 5'd10, 5'd11, 5'd0, 3'b000, 7'd0, 32'd1, n_wait);
    req(OpcOpImm, 5'd12, 5'd13, 5'd0, 3'b000, 7'd0, 32'd2, n_wait);
    bus.opcode_i = OpcOpImm; bus.rd_i = 5'd14; bus.rs1_i = 5'd15; bus.imm_i = 32'd3;
    bus.in_valid_i = 1'b1;
    cycle();
    check("stall_full_accept", 64'(acc), 64'd0);
    cycle();
    cycle();
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (acc) bus.in_valid_i = 1'b0;
    end
    check("stall_drained", 64'(sb.size()), 64'd0);
    check("stall_in_valid_done", 64'(bus.in_valid_i), 64'd0);

    for (int i = 0; i < 300; i++) req(7'b1111111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, n_wait);
    drain(2);
    check("err_cnt_sat", 64'(obs_cnt), 64'd255);

    // Asynchronous reset with two entries queued.
    bus.out_ready_i = 1'b0;
    req(OpcLoad, 5'd1, 5'd2, 5'd0, 3'b010, 7'd0, 32'd4, n_wait);
    req(OpcLoad, 5'd3, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8, n_wait);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("midrst_cnt", 64'(bus.err_cnt_o), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("midrst_instr", 64'(bus.instr_o), 64'd0);
    sb.delete();
    exp_cnt = 8'd0;
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    req(OpcStore, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8, n_wait);
    check("post_rst_accept_wait", 64'(n_wait), 64'd0);
    cycle();
    check("post_rst_instr", 64'(obs_instr), 64'h0051_2423);
    drain(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
